// File: rtl/rr_arb4_pkg.sv
// Shared types and constants for the 4-way round-robin arbiter.
package rr_arb4_pkg;
    localparam int IDX_W = 2;
    localparam int N_REQ = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    function automatic logic [N_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
        logic [N_REQ-1:0] v;
        v = '0;
        v[idx] = 1'b1;
        return v;
    endfunction
endpackage

// File: rtl/rr_pick4.sv
// Rotating-priority pick: first set req bit scanning ptr+1, ptr+2, ptr+3, ptr (mod 4).
// Purely combinational; any is low when no request is set.
module rr_pick4
    import rr_arb4_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] idx,
    output logic             any
);
    always_comb begin
        logic [IDX_W-1:0] cand;
        idx = '0;
        any = 1'b0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = ptr + IDX_W'(k);
            if (!any && req[cand]) begin
                idx = cand;
                any = 1'b1;
            end
        end
    end
endmodule

// File: rtl/rr_arb4.sv
// 4-requester round-robin arbiter with registered one-hot grant and 4:1 payload mux.
// Optional per-grant burst limit enabled by defining RR_ARB4_BURST_LIMIT_EN.
module rr_arb4
    import rr_arb4_pkg::*;
#(
    parameter int DATA_W    = 2,
    parameter int MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        req,
    input  logic [DATA_W-1:0] p0,
    input  logic [DATA_W-1:0] p1,
    input  logic [DATA_W-1:0] p2,
    input  logic [DATA_W-1:0] p3,
    input  logic              dout_ready,
    output logic [3:0]        gnt,
    output logic [1:0]        sel,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid
);
    if (MAX_BURST < 1 || MAX_BURST > 255) begin : g_bad_burst
        $error("rr_arb4: MAX_BURST out of range 1..255");
    end

    state_t           state;
    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_any;
    logic             xfer;

    rr_pick4 u_pick (
        .req (req),
        .ptr (ptr),
        .idx (pick_idx),
        .any (pick_any)
    );

    // Outputs are forced quiet while rst is sampled high so no transfer is seen that cycle.
    always_comb begin
        dout       = '0;
        dout_valid = 1'b0;
        if (state == GRANT && !rst) begin
            dout_valid = req[sel];
            case (sel)
                2'd0:    dout = p0;
                2'd1:    dout = p1;
                2'd2:    dout = p2;
                default: dout = p3;
            endcase
        end
    end

    assign xfer = dout_valid && dout_ready;

`ifdef RR_ARB4_BURST_LIMIT_EN
    logic [7:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            gnt   <= '0;
            sel   <= '0;
            ptr   <= 2'd3;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        state <= GRANT;
                        sel   <= pick_idx;
                        gnt   <= onehot(pick_idx);
                        ptr   <= pick_idx;
                        cnt   <= '0;
                    end
                end
                GRANT: begin
                    if (!req[sel]) begin
                        state <= IDLE;
                        gnt   <= '0;
                    end else if (xfer) begin
                        if (cnt + 8'd1 == 8'(MAX_BURST)) begin
                            state <= IDLE;
                            gnt   <= '0;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + 8'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
`else
    logic unused_xfer;
    assign unused_xfer = xfer;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            gnt   <= '0;
            sel   <= '0;
            ptr   <= 2'd3;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        state <= GRANT;
                        sel   <= pick_idx;
                        gnt   <= onehot(pick_idx);
                        ptr   <= pick_idx;
                    end
                end
                GRANT: begin
                    if (!req[sel]) begin
                        state <= IDLE;
                        gnt   <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
`endif
endmodule

// File: tb/tb_rr_arb4.sv
// Directed, table-driven bench for rr_arb4 with distinct payloads per requester.
module tb_rr_arb4;
    localparam int DW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [3:0]    req;
    logic [DW-1:0] p0, p1, p2, p3;
    logic          dout_ready;
    logic [3:0]    gnt;
    logic [1:0]    sel;
    logic [DW-1:0] dout;
    logic          dout_valid;

    int n_tests = 0;
    int n_fail  = 0;

    rr_arb4 #(.DATA_W(DW), .MAX_BURST(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .p0         (p0),
        .p1         (p1),
        .p2         (p2),
        .p3         (p3),
        .dout_ready (dout_ready),
        .gnt        (gnt),
        .sel        (sel),
        .dout       (dout),
        .dout_valid (dout_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          rst;
        logic [3:0]    req;
        logic          rdy;
        logic [3:0]    gnt;
        logic          vld;
        logic [DW-1:0] dout;
    } vec_t;

    vec_t vec [26];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    initial begin
        p0 = 4'hA; p1 = 4'hB; p2 = 4'hC; p3 = 4'hD;
        rst = 1'b1; req = 4'b0000; dout_ready = 1'b1;

        //           rst  req      rdy   gnt      vld   dout
        vec[0]  = '{1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, 4'h0};
        vec[1]  = '{1'b0, 4'b0001, 1'b1, 4'b0000, 1'b0, 4'h0};
        vec[2]  = '{1'b0, 4'b0001, 1'b1, 4'b0001, 1'b1, 4'hA};
        vec[3]  = '{1'b0, 4'b0001, 1'b1, 4'b0001, 1'b1, 4'hA};
        vec[4]  = '{1'b0, 4'b0000, 1'b1, 4'b0001, 1'b0, 4'hA};
        vec[5]  = '{1'b0, 4'b1111, 1'b1, 4'b0000, 1'b0, 4'h0};
        vec[6]  = '{1'b0, 4'b1101, 1'b1, 4'b0010, 1'b0, 4'hB};
        vec[7]  = '{1'b0, 4'b1111, 1'b1, 4'b0000, 1'b0, 4'h0};
        vec[8]  = '{1'b0, 4'b1011, 1'b1, 4'b0100, 1'b0, 4'hC};
        vec[9]  = '{1'b0, 4'b1111, 1'b1, 4'b0000, 1'b0, 4'h0};
        vec[10] = '{1'b0, 4'b0111, 1'b1, 4'b1000, 1'b0, 4'hD};
        vec[11] = '{1'b0, 4'b1111, 1'b1, 4'b0000, 1'b0, 4'h0};
        vec[12] = '{1'b0, 4'b1110, 1'b1, 4'b0001, 1'b0, 4'hA};
        vec[13] = '{1'b0, 4'b0100, 1'b0, 4'b0000, 1'b0, 4'h0};
        vec[14] = '{1'b0, 4'b0100, 1'b0, 4'b0100, 1'b1, 4'hC};
        vec[15] = '{1'b0, 4'b0100, 1'b0, 4'b0100, 1'b1, 4'hC};
        vec[16] = '{1'b0, 4'b0100, 1'b0, 4'b0100, 1'b1, 4'hC};
        vec[17] = '{1'b0, 4'b0100, 1'b1, 4'b0100, 1'b1, 4'hC};
        vec[18] = '{1'b0, 4'b1111, 1'b1, 4'b0100, 1'b1, 4'hC};
        vec[19] = '{1'b0, 4'b1111, 1'b1, 4'b0100, 1'b1, 4'hC};
        vec[20] = '{1'b0, 4'b1011, 1'b1, 4'b0100, 1'b0, 4'hC};
        vec[21] = '{1'b0, 4'b1000, 1'b1, 4'b0000, 1'b0, 4'h0};
        vec[22] = '{1'b0, 4'b1000, 1'b1, 4'b1000, 1'b1, 4'hD};
        vec[23] = '{1'b1, 4'b1001, 1'b1, 4'b1000, 1'b0, 4'h0};
        vec[24] = '{1'b0, 4'b1001, 1'b1, 4'b0000, 1'b0, 4'h0};
        vec[25] = '{1'b0, 4'b1001, 1'b1, 4'b0001, 1'b1, 4'hA};

        tick();
        tick();

        for (int i = 0; i < 26; i++) begin
            rst        = vec[i].rst;
            req        = vec[i].req;
            dout_ready = vec[i].rdy;
            #1;
            check($sformatf("vec%0d_gnt", i),  32'(gnt),        32'(vec[i].gnt));
            check($sformatf("vec%0d_vld", i),  32'(dout_valid), 32'(vec[i].vld));
            check($sformatf("vec%0d_dout", i), 32'(dout),       32'(vec[i].dout));
            tick();
        end

        // Long hold of two requests: burst limit hands over, otherwise grant persists.
        rst = 1'b1; req = 4'b0000; dout_ready = 1'b1;
        tick();
        rst = 1'b0; req = 4'b0011;
        #1;
        check("burst_start_gnt", 32'(gnt), 32'h0);
        tick();
        for (int i = 0; i < 4; i++) begin
            check($sformatf("burst%0d_gnt", i),  32'(gnt),        32'h1);
            check($sformatf("burst%0d_vld", i),  32'(dout_valid), 32'h1);
            check($sformatf("burst%0d_dout", i), 32'(dout),       32'hA);
            tick();
        end
`ifdef RR_ARB4_BURST_LIMIT_EN
        check("burst_bubble_gnt", 32'(gnt), 32'h0);
        check("burst_bubble_vld", 32'(dout_valid), 32'h0);
        tick();
        check("burst_next_gnt",  32'(gnt),  32'h2);
        check("burst_next_dout", 32'(dout), 32'hB);
`else
        check("hold_gnt_a", 32'(gnt), 32'h1);
        tick();
        check("hold_gnt_b", 32'(gnt), 32'h1);
        check("hold_sel_b", 32'(sel), 32'h0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
